// File: rtl/prm_pkg.sv
// Shared types and helpers for the PRM edge-mask accumulator.
// Holds widths, FSM states and the word popcount.
package prm_pkg;

  localparam int OBS_W       = 15;
  localparam int N_EDGES_DEF = 512;
  localparam int RD_W_DEF    = 32;
  localparam int PC_W_DEF    = $clog2(RD_W_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    COUNT,
    DONE
  } state_t;

  function automatic logic [PC_W_DEF-1:0] popcnt_word(
    input logic [RD_W_DEF-1:0] w
  );
    logic [PC_W_DEF-1:0] c;
    c = '0;
    for (int i = 0; i < RD_W_DEF; i++) begin
      c = c + PC_W_DEF'(w[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prm_edge_mask_accum_popcnt.sv
// Combinational popcount of one bitmap readout word.
// Module name prm_word_popcnt; used by the COUNT scan.
module prm_word_popcnt
  import prm_pkg::*;
#(
  parameter int RD_W = RD_W_DEF,
  parameter int PC_W = $clog2(RD_W + 1)
) (
  input  logic [RD_W-1:0] word_i,
  output logic [PC_W-1:0] cnt_o
);

  if (RD_W == RD_W_DEF && PC_W == PC_W_DEF) begin : g_pkg
    assign cnt_o = popcnt_word(word_i);
  end else begin : g_loop
    always_comb begin
      cnt_o = '0;
      for (int i = 0; i < RD_W; i++) begin
        cnt_o = cnt_o + PC_W'(word_i[i]);
      end
    end
  end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Streams obstacle codes to the checker bank, ORs masks into a
// blocked-edge bitmap, counts blocked edges and serves word reads.
module prm_edge_mask_accum
  import prm_pkg::*;
#(
  parameter  int N_EDGES = N_EDGES_DEF,
  parameter  int RD_W    = RD_W_DEF,
  localparam int NW      = N_EDGES / RD_W,
  localparam int AW      = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW      = $clog2(N_EDGES + 1),
  localparam int PCW     = $clog2(RD_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               obs_valid,
  input  logic [OBS_W-1:0]   obs_code,
  input  logic               obs_last,
  output logic               obs_ready,
  output logic [OBS_W-1:0]   chk_code,
  input  logic [N_EDGES-1:0] chk_mask,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      blocked_cnt,
  input  logic [AW-1:0]      rd_addr,
  output logic [RD_W-1:0]    rd_data
);

  state_t             state_q, state_d;
  logic [N_EDGES-1:0] bitmap_q;
  logic [OBS_W-1:0]   chk_code_q;
  logic               s2_valid_q;
  logic [AW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [RD_W-1:0]    rd_data_q;
  logic [RD_W-1:0]    word_w [NW];
  logic [PCW-1:0]     pc_w;
  logic               hs;

  for (genvar g = 0; g < NW; g++) begin : g_word
    assign word_w[g] = bitmap_q[g*RD_W +: RD_W];
  end

  prm_word_popcnt #(
    .RD_W (RD_W),
    .PC_W (PCW)
  ) u_popcnt (
    .word_i (word_w[idx_q]),
    .cnt_o  (pc_w)
  );

  assign hs = obs_valid & obs_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (hs && obs_last) state_d = DRAIN;
      DRAIN:   state_d = COUNT;
      COUNT:   if (idx_q == AW'(NW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obs_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      RUN: begin
        obs_ready = 1'b1;
        busy      = 1'b1;
      end
      DRAIN, COUNT: busy = 1'b1;
      DONE:         done = 1'b1;
      default: ;
    endcase
  end

  // Mask for a code arrives the cycle after it is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q   <= '0;
      chk_code_q <= '0;
      s2_valid_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      s2_valid_q <= hs;
      if (hs) chk_code_q <= obs_code;
      if (state_q == IDLE && start) begin
        bitmap_q <= '0;
        cnt_q    <= '0;
      end else if (s2_valid_q) begin
        bitmap_q <= bitmap_q | chk_mask;
      end
      if (state_q == DRAIN) begin
        idx_q <= '0;
      end else if (state_q == COUNT) begin
        idx_q <= idx_q + AW'(1);
        cnt_q <= cnt_q + CW'(pc_w);
      end
      rd_data_q <= word_w[rd_addr];
    end
  end

  assign chk_code    = chk_code_q;
  assign blocked_cnt = cnt_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Self-checking bench for prm_edge_mask_accum with a stub checker bank.
module tb_prm_edge_mask_accum;

  localparam int N  = 512;
  localparam int RW = 32;
  localparam int NW = N / RW;
  localparam int OW = 15;
  localparam int AW = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst, start, obs_valid, obs_last;
  logic [OW-1:0] obs_code;
  logic          obs_ready;
  logic [OW-1:0] chk_code;
  logic [N-1:0]  chk_mask;
  logic          busy, done;
  logic [CW-1:0] blocked_cnt;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] mtab [int];
  int           tab_ver = 0;

  int           lat, done_pulses, rdy_cycles;
  logic         busy_at_done, busy_after_rst;
  logic [CW-1:0] cnt_at_done;
  logic [N-1:0] exp_bm;

  prm_edge_mask_accum dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .obs_valid   (obs_valid),
    .obs_code    (obs_code),
    .obs_last    (obs_last),
    .obs_ready   (obs_ready),
    .chk_code    (chk_code),
    .chk_mask    (chk_mask),
    .busy        (busy),
    .done        (done),
    .blocked_cnt (blocked_cnt),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_mask(input int code);
    if (mtab.exists(code)) return mtab[code];
    return '0;
  endfunction

  // Stub checker bank: pure lookup on the registered code.
  always @(chk_code or tab_ver) chk_mask = model_mask(int'(chk_code));

  task automatic set_mask(input int code, input logic [N-1:0] m);
    mtab[code] = m;
    tab_ver++;
  endtask

  function automatic logic [N-1:0] rand_mask(input int kind);
    logic [N-1:0] a, b;
    for (int w = 0; w < NW; w++) begin
      a[w*RW +: RW] = $urandom;
      b[w*RW +: RW] = $urandom;
    end
    case (kind)
      0: return '0;
      1: begin
        a = '0;
        a[$urandom_range(N-1)] = 1'b1;
        return a;
      end
      2: return a & b;
      default: return a;
    endcase
  endfunction

  task automatic run_query(input int codes[$], input int gap_pct,
                           input bit extra_start, input int rst_at);
    exp_bm         = '0;
    rdy_cycles     = 0;
    done_pulses    = 0;
    lat            = -1;
    cnt_at_done    = '0;
    busy_at_done   = 1'b1;
    busy_after_rst = 1'b1;
    foreach (codes[i]) exp_bm |= model_mask(codes[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (codes[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        obs_valid = 1'b0;
        @(negedge clk);
      end
      obs_valid = 1'b1;
      obs_code  = OW'(codes[i]);
      obs_last  = (i == codes.size() - 1);
      if (extra_start && i == 0) start = 1'b1;
      if (obs_ready) rdy_cycles++;
      @(negedge clk);
      start = 1'b0;
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        done_pulses++;
        if (lat < 0) begin
          lat          = k;
          cnt_at_done  = blocked_cnt;
          busy_at_done = busy;
        end
      end
      if (rst_at != 0 && k == rst_at + 1) busy_after_rst = busy;
      if (extra_start && k == 6) start = 1'b1;
      if (rst_at == k) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
    end
  endtask

  task automatic read_bitmap(output logic [N-1:0] bm);
    bm = '0;
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      rd_addr = AW'(w);
      @(negedge clk);
      bm[w*RW +: RW] = rd_data;
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] bm;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({obs_ready, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 000", {obs_ready, busy, done});
    end
    n_cmp++;
    if (blocked_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt got %0d want 0", blocked_cnt);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm !== '0) begin
      n_err++;
      $display("FAIL reset_bitmap got %h want 0", bm);
    end
    obs_valid = 1'b1;
    obs_code  = 15'h1234;
    repeat (3) @(negedge clk);
    obs_valid = 1'b0;
    n_cmp++;
    if (chk_code !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_valid chk_code %h busy %b want 0 0",
               chk_code, busy);
    end
  endtask

  task automatic test_single();
    int           q[$];
    logic [N-1:0] m, bm;
    mtab.delete();
    m = '0;
    m[3] = 1'b1;
    m[100] = 1'b1;
    m[511] = 1'b1;
    set_mask(16'h4B0A, m);
    q = {16'h4B0A};
    run_query(q, 0, 1'b0, 0);
    n_cmp++;
    if (lat !== 18) begin
      n_err++;
      $display("FAIL single_latency got %0d want 18", lat);
    end
    n_cmp++;
    if (done_pulses !== 1 || busy_at_done !== 1'b0) begin
      n_err++;
      $display("FAIL single_done pulses %0d busy %b want 1 0",
               done_pulses, busy_at_done);
    end
    n_cmp++;
    if (cnt_at_done !== CW'(3) || blocked_cnt !== CW'(3)) begin
      n_err++;
      $display("FAIL single_cnt got %0d/%0d want 3",
               cnt_at_done, blocked_cnt);
    end
    n_cmp++;
    if (chk_code !== 15'h4B0A) begin
      n_err++;
      $display("FAIL single_chk_code got %h want 4b0a", chk_code);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm[31:0] !== 32'h8 || bm[96+4] !== 1'b1 ||
        bm[511:480] !== 32'h80000000 || bm !== exp_bm) begin
      n_err++;
      $display("FAIL single_bitmap got %h want %h", bm, exp_bm);
    end
  endtask

  task automatic test_back_to_back();
    int           q[$];
    logic [N-1:0] m, bm;
    mtab.delete();
    for (int c = 0; c < 8; c++) begin
      m = '0;
      m[c % N] = 1'b1;
      set_mask(c, m);
      q.push_back(c);
    end
    run_query(q, 0, 1'b0, 0);
    n_cmp++;
    if (rdy_cycles !== 8 || lat !== 18) begin
      n_err++;
      $display("FAIL b2b_ready ready %0d lat %0d want 8 18",
               rdy_cycles, lat);
    end
    n_cmp++;
    if (cnt_at_done !== CW'(8)) begin
      n_err++;
      $display("FAIL b2b_cnt got %0d want 8", cnt_at_done);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm[31:0] !== 32'hFF || bm !== exp_bm) begin
      n_err++;
      $display("FAIL b2b_bitmap got %h want %h", bm, exp_bm);
    end
  endtask

  task automatic test_empty_full();
    int           q[$];
    logic [N-1:0] m, bm;
    mtab.delete();
    q = {16'h10, 16'h11};
    run_query(q, 20, 1'b0, 0);
    n_cmp++;
    if (cnt_at_done !== '0 || lat !== 18) begin
      n_err++;
      $display("FAIL empty_cnt got %0d lat %0d want 0 18",
               cnt_at_done, lat);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm !== '0) begin
      n_err++;
      $display("FAIL empty_bitmap got %h want 0", bm);
    end
    set_mask(16'h20, '1);
    m = '0;
    m[7] = 1'b1;
    set_mask(16'h21, m);
    q = {16'h20, 16'h21};
    run_query(q, 0, 1'b0, 0);
    n_cmp++;
    if (cnt_at_done !== CW'(512)) begin
      n_err++;
      $display("FAIL full_cnt got %0d want 512", cnt_at_done);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm !== {N{1'b1}}) begin
      n_err++;
      $display("FAIL full_bitmap got %h want all ones", bm);
    end
  endtask

  task automatic test_start_busy();
    int            q[$];
    logic [N-1:0]  bm1, bm2;
    logic [CW-1:0] c1;
    mtab.delete();
    for (int i = 0; i < 5; i++) begin
      set_mask(i + 100, rand_mask(2));
      q.push_back(i + 100);
    end
    run_query(q, 0, 1'b0, 0);
    c1 = cnt_at_done;
    read_bitmap(bm1);
    run_query(q, 0, 1'b1, 0);
    read_bitmap(bm2);
    n_cmp++;
    if (done_pulses !== 1 || lat !== 18) begin
      n_err++;
      $display("FAIL startbusy_done pulses %0d lat %0d want 1 18",
               done_pulses, lat);
    end
    n_cmp++;
    if (cnt_at_done !== c1 ||
        cnt_at_done !== CW'($countones(exp_bm))) begin
      n_err++;
      $display("FAIL startbusy_cnt got %0d want %0d",
               cnt_at_done, $countones(exp_bm));
    end
    n_cmp++;
    if (bm2 !== bm1 || bm2 !== exp_bm) begin
      n_err++;
      $display("FAIL startbusy_bitmap got %h want %h", bm2, exp_bm);
    end
  endtask

  task automatic test_reset_mid();
    int           q[$];
    logic [N-1:0] bm;
    mtab.delete();
    for (int i = 0; i < 4; i++) begin
      set_mask(i + 7, rand_mask(3));
      q.push_back(i + 7);
    end
    run_query(q, 0, 1'b0, 8);
    n_cmp++;
    if (done_pulses !== 0 || busy_after_rst !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort pulses %0d busy %b want 0 0",
               done_pulses, busy_after_rst);
    end
    n_cmp++;
    if (blocked_cnt !== '0) begin
      n_err++;
      $display("FAIL rstmid_cnt got %0d want 0", blocked_cnt);
    end
    read_bitmap(bm);
    n_cmp++;
    if (bm !== '0) begin
      n_err++;
      $display("FAIL rstmid_bitmap got %h want 0", bm);
    end
    run_query(q, 10, 1'b0, 0);
    read_bitmap(bm);
    n_cmp++;
    if (cnt_at_done !== CW'($countones(exp_bm)) || bm !== exp_bm) begin
      n_err++;
      $display("FAIL rstmid_fresh cnt %0d want %0d",
               cnt_at_done, $countones(exp_bm));
    end
  endtask

  task automatic test_random();
    int           q[$];
    int           pool[6];
    logic [N-1:0] bm;
    mtab.delete();
    for (int i = 0; i < 6; i++) begin
      pool[i] = int'($urandom_range(32767));
      set_mask(pool[i], rand_mask(int'($urandom_range(3))));
    end
    for (int t = 0; t < 6; t++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(8, 1)); i++) begin
        q.push_back(pool[$urandom_range(5)]);
      end
      run_query(q, 30, 1'b0, 0);
      n_cmp++;
      if (lat !== 18 ||
          cnt_at_done !== CW'($countones(exp_bm))) begin
        n_err++;
        $display("FAIL random_cnt[%0d] got %0d lat %0d want %0d 18",
                 t, cnt_at_done, lat, $countones(exp_bm));
      end
      read_bitmap(bm);
      n_cmp++;
      if (bm !== exp_bm) begin
        n_err++;
        $display("FAIL random_bitmap[%0d] got %h want %h",
                 t, bm, exp_bm);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    obs_code  = '0;
    rd_addr   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_full();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
